// File: rtl/msg_scheduler.sv
// SHA-256 message scheduler.
// Accepts one 512-bit padded block, then issues the 64 schedule words W_t
// (one per cycle) from a 16-word sliding window, followed by a one-cycle
// done pulse. Optional macro MSG_SCHDL_KROM_EN builds an internal K_t ROM;
// without it o_round_constant is tied to 0 and K is looked up externally
// using o_round_idx.
//
// Handshake: a block transfers on a rising edge where i_blk_valid=1 and
// o_blk_ready=1. o_blk_ready never depends on i_blk_valid. The source holds
// i_blk_valid and i_msg_blk stable until the transfer; valid seen while
// busy (RUN/DONE) is simply not accepted.
module msg_scheduler #(
   parameter int BLK_SIZE = 512,
   parameter int WRD_SIZE = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_blk_valid,
   input  logic [BLK_SIZE-1:0] i_msg_blk,
   output logic                o_blk_ready,
   output logic                o_round_en,
   output logic [WRD_SIZE-1:0] o_msg_wrd,
   output logic [5:0]          o_round_idx,
   output logic [WRD_SIZE-1:0] o_round_constant,
   output logic                o_done,
   output logic [1:0]          o_fsm_state
);

   localparam int NWORDS = BLK_SIZE / WRD_SIZE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                rdy_q;
   logic [5:0]          t_q;
   logic [WRD_SIZE-1:0] win_q [NWORDS];
   logic [WRD_SIZE-1:0] w_new;
   logic [WRD_SIZE-1:0] k_t;
   logic                accept;

   function automatic logic [WRD_SIZE-1:0] rotr(input logic [WRD_SIZE-1:0] x, input int n);
      return (x >> n) | (x << (WRD_SIZE - n));
   endfunction

   function automatic logic [WRD_SIZE-1:0] sigma0(input logic [WRD_SIZE-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WRD_SIZE-1:0] sigma1(input logic [WRD_SIZE-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

`ifdef MSG_SCHDL_KROM_EN
   localparam logic [31:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   assign k_t = K_ROM[t_q];
`else
   assign k_t = '0;
`endif

   assign accept      = i_blk_valid && o_blk_ready;
   assign o_fsm_state = state;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: IDLE -> RUN on accept, RUN for 64 rounds, DONE for one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (t_q == 6'd63) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Ready is held low while reset is asserted and rises on the first edge after release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdy_q <= 1'b0;
      else       rdy_q <= 1'b1;
   end

   // Round counter: restarts at 0 on accept, steps once per RUN cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)              t_q <= '0;
      else if (accept)        t_q <= '0;
      else if (state == RUN)  t_q <= t_q + 6'd1;
   end

   // Next schedule word from the window; win_q[i] holds W_{t+i}.
   always_comb begin
      w_new = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
   end

   // Sliding window: load the block on accept, shift one word per round.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NWORDS; i++) win_q[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < NWORDS; i++)
            win_q[i] <= i_msg_blk[BLK_SIZE-1-i*WRD_SIZE -: WRD_SIZE];
      end else if (state == RUN) begin
         for (int i = 0; i < NWORDS-1; i++) win_q[i] <= win_q[i+1];
         win_q[NWORDS-1] <= w_new;
      end
   end

   // Outputs: round data only while RUN, zero otherwise.
   always_comb begin
      o_blk_ready      = rdy_q && (state == IDLE);
      o_round_en       = 1'b0;
      o_msg_wrd        = '0;
      o_round_idx      = '0;
      o_round_constant = '0;
      o_done           = (state == DONE);
      if (state == RUN) begin
         o_round_en       = 1'b1;
         o_msg_wrd        = win_q[0];
         o_round_idx      = t_q;
         o_round_constant = k_t;
      end
   end

endmodule
